// File: rtl/tatzel_spi_cfg_responder.sv
// SPI mode-0 configuration target: 16-bit frames {wr, addr[6:0], data[7:0]} load
// or read back an NREGS x 8-bit register bank; all SPI pins are oversampled on clk.
module tatzel_spi_cfg_responder #(
    parameter int unsigned NREGS     = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               spi_sclk,
    input  logic               spi_cs_n,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               spi_miso_oe,
    output logic [NREGS*8-1:0] cfg_flat,
    output logic               wr_stb,
    output logic [6:0]         wr_addr
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_DONE, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  sclk_q, cs_q;
    logic [1:0]  mosi_q;
    logic        sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic [3:0]  bit_cnt;
    logic [7:0]  rx_sr, rx_byte, tx_sr;
    logic        cmd_wr, skip_fall, addr_ok;
    logic [6:0]  cmd_addr;
    logic        clr, shift, cmd_end, commit;
    logic [7:0]  regs [NREGS];

    // Stages [1:0] synchronise; stage [2] holds the previous sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            cs_q   <= {cs_q[1:0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign mosi_s    = mosi_q[1];
    assign rx_byte   = {rx_sr[6:0], mosi_s};
    assign addr_ok   = 32'(cmd_addr) < NREGS;

    function automatic logic [7:0] rd_reg(input logic [6:0] a);
        rd_reg = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            if (32'(a) == i) rd_reg = regs[i];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // cs_n rise is tested before sclk rise so a coincident 16th edge aborts the frame.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shift     = 1'b0;
        cmd_end   = 1'b0;
        commit    = 1'b0;
        if (!ena) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (cs_fall) begin
                    clr       = 1'b1;
                    state_nxt = S_CMD;
                end
                S_CMD: if (cs_rise) begin
                    state_nxt = S_IDLE;
                end else if (sclk_rise) begin
                    shift = 1'b1;
                    if (bit_cnt == 4'd7) begin
                        cmd_end   = 1'b1;
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: if (cs_rise) begin
                    state_nxt = S_IDLE;
                end else if (sclk_rise) begin
                    shift = 1'b1;
                    if (bit_cnt == 4'd15) state_nxt = S_DONE;
                end
                S_DONE: begin
                    commit    = cmd_wr & addr_ok;
                    state_nxt = S_WAIT;
                end
                S_WAIT: if (cs_rise) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // After 16 shifts rx_sr holds only the data byte, so it feeds the commit directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            skip_fall <= 1'b0;
        end else begin
            if (clr) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 4'd1;
                rx_sr   <= rx_byte;
            end
            if (cmd_end) begin
                cmd_wr    <= rx_byte[7];
                cmd_addr  <= rx_byte[6:0];
                tx_sr     <= rx_byte[7] ? 8'h00 : rd_reg(rx_byte[6:0]);
                skip_fall <= 1'b1;
            end else if (state == S_DATA && sclk_fall) begin
                if (skip_fall) skip_fall <= 1'b0;
                else           tx_sr     <= {tx_sr[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_stb <= commit;
            if (commit) begin
                wr_addr <= cmd_addr;
                for (int unsigned i = 0; i < NREGS; i++)
                    if (32'(cmd_addr) == i) regs[i] <= rx_sr;
            end
        end
    end

    always_comb begin
        cfg_flat = '0;
        for (int unsigned i = 0; i < NREGS; i++) cfg_flat[8*i +: 8] = regs[i];
    end

    assign spi_miso    = (state == S_DATA) & ~cmd_wr & tx_sr[7];
    assign spi_miso_oe = (state != S_IDLE) & ~cs_q[1];

endmodule

// File: tb/tb_tatzel_spi_cfg_responder.sv
// Scoreboard bench for tatzel_spi_cfg_responder: directed SPI frames push expected
// writes/reads into queues; monitors pop and compare on wr_stb and completed reads.
module tb_tatzel_spi_cfg_responder;

    localparam int unsigned NREGS = 4;
    localparam logic [7:0]  RV    = 8'h00;

    logic               clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic               sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic               spi_miso, spi_miso_oe, wr_stb;
    logic [NREGS*8-1:0] cfg_flat;
    logic [6:0]         wr_addr;

    tatzel_spi_cfg_responder #(.NREGS(NREGS), .RESET_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .cfg_flat(cfg_flat), .wr_stb(wr_stb), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] model [NREGS];
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    wr_t        cur_wr;
    logic [7:0] rx_byte;
    logic [15:0] frm;
    event       rx_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bank(input string name);
        for (int i = 0; i < int'(NREGS); i++) check(name, 32'(cfg_flat[8*i +: 8]), 32'(model[i]));
    endtask

    // Write monitor: every wr_stb must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (rst_n && wr_stb) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_wr_stb", 32'd1, 32'd0);
            end else begin
                cur_wr = exp_wr.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(cur_wr.addr));
                check("wr_data", 32'(cfg_flat[8*int'(cur_wr.addr) +: 8]), 32'(cur_wr.data));
            end
        end
    end

    initial begin
        forever begin
            @(rx_done);
            if (exp_rd.size() == 0) check("unexpected_read", 32'd1, 32'd0);
            else                    check("read_data", 32'(rx_byte), 32'(exp_rd.pop_front()));
        end
    end

    // MISO is sampled just before each rising sclk, as a mode-0 host would.
    task automatic spi_frame(input logic [23:0] bits, input int nbits, input int stop_after,
                             input logic exp_oe, input logic is_read);
        logic [7:0] rx;
        rx   = '0;
        cs_n = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            mosi = bits[nbits-1-i];
            #50;
            if (i >= 8 && i < 16) rx = {rx[6:0], spi_miso};
            sclk = 1'b1;
            if (i == 4) check("oe_in_frame", 32'(spi_miso_oe), 32'(exp_oe));
            #50;
            sclk = 1'b0;
            if (stop_after == i + 1) break;
        end
        #100;
        cs_n = 1'b1;
        #100;
        check("oe_after_frame", 32'(spi_miso_oe), 32'd0);
        if (is_read) begin
            rx_byte = rx;
            -> rx_done;
        end
        #100;
    endtask

    initial begin
        for (int i = 0; i < int'(NREGS); i++) model[i] = RV;
        #23;
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check_bank("rst_bank");
        rst_n = 1'b1;
        #50;

        // T1 write addr 1 = A5
        exp_wr.push_back('{addr: 7'd1, data: 8'hA5});
        model[1] = 8'hA5;
        spi_frame(24'h0081A5, 16, 0, 1'b1, 1'b0);
        check_bank("t1_bank");

        // T2 read addr 1
        exp_rd.push_back(8'hA5);
        spi_frame(24'h000100, 16, 0, 1'b1, 1'b1);

        // T3 abort after 12 bits, then the full frame
        spi_frame(24'h00823C, 16, 12, 1'b1, 1'b0);
        check_bank("t3_abort_bank");
        exp_wr.push_back('{addr: 7'd2, data: 8'h3C});
        model[2] = 8'h3C;
        spi_frame(24'h00823C, 16, 0, 1'b1, 1'b0);
        check_bank("t3_full_bank");
        exp_rd.push_back(8'h3C);
        spi_frame(24'h000200, 16, 0, 1'b1, 1'b1);

        // T4 out of range write and read
        spi_frame(24'h00FF55, 16, 0, 1'b1, 1'b0);
        check_bank("t4_bank");
        exp_rd.push_back(8'h00);
        spi_frame(24'h007F00, 16, 0, 1'b1, 1'b1);

        // T5 overlength frame: 24 clocks, one write
        exp_wr.push_back('{addr: 7'd0, data: 8'h5A});
        model[0] = 8'h5A;
        spi_frame(24'h805AFF, 24, 0, 1'b1, 1'b0);
        check_bank("t5_bank");

        exp_wr.push_back('{addr: 7'd3, data: 8'hC3});
        model[3] = 8'hC3;
        spi_frame(24'h0083C3, 16, 0, 1'b1, 1'b0);
        check_bank("w3_bank");

        // T6a ena=0 blocks a full write frame
        ena = 1'b0;
        #50;
        spi_frame(24'h0082FF, 16, 0, 1'b0, 1'b0);
        check_bank("t6_ena_bank");
        ena = 1'b1;
        #50;

        // T6b reset in the middle of a read of addr 3
        frm  = 16'h0300;
        cs_n = 1'b0;
        #100;
        for (int i = 0; i < 10; i++) begin
            mosi = frm[15-i];
            #50;
            sclk = 1'b1;
            #50;
            sclk = 1'b0;
        end
        #50;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < int'(NREGS); i++) model[i] = RV;
        check("mid_rst_wr_stb", 32'(wr_stb), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_miso", 32'(spi_miso), 32'd0);
        check("mid_rst_oe", 32'(spi_miso_oe), 32'd0);
        check_bank("mid_rst_bank");
        cs_n = 1'b1;
        mosi = 1'b0;
        #30;
        rst_n = 1'b1;
        #100;

        exp_wr.push_back('{addr: 7'd1, data: 8'h77});
        model[1] = 8'h77;
        spi_frame(24'h008177, 16, 0, 1'b1, 1'b0);
        check_bank("post_rst_bank");

        #200;
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
